// File: rtl/spixel_animator.sv
// spixel_animator
//   Superpixel sprite sequencer placed between user logic and draw_superpixel.
//   Every accepted move erases the sprite's previous cell and then draws the
//   new cell. The motion modes are raster, diagonal bounce and externally
//   stepped. A tick or step that arrives while a move is in flight is dropped
//   and latches a sticky overrun flag.
//
//   Ports:
//     clk       clock (CLOCK_50 domain)
//     rst       synchronous reset, active-high
//     ien       enables the prescaler and move acceptance
//     imode     00 raster, 01 bounce, 10 step, 11 hold
//     istep     single-cycle step pulse; acts as the trigger in mode 10
//     ifg       sprite colour, sampled when a move is latched
//     ox, oy    cell coordinates sent to draw_superpixel
//     ocolor    fill colour sent to draw_superpixel
//     ovld      single-cycle request pulse to draw_superpixel
//     idone     completion pulse from draw_superpixel
//     obusy     high from move acceptance until the draw completes
//     ooverrun  sticky; a trigger arrived while busy
//
//   Optional feature macro: SPIXEL_ANIM_TRAIL_EN
//     When defined, the erase pass paints ifg with its MSB inverted, which
//     leaves a trail behind the sprite. When undefined, the erase pass
//     paints BG_COLOR.

module spixel_animator #(
  parameter int SPIXEL_X_WIDTH = 5,
  parameter int SPIXEL_Y_WIDTH = 5,
  parameter int SPIXEL_X_MAX   = 32,
  parameter int SPIXEL_Y_MAX   = 24,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int TICK_CNT_WIDTH = 25,
  parameter int TICK_PERIOD    = 12500000,
  parameter logic [COLOR_ID_WIDTH-1:0] BG_COLOR = 8'hff
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ien,
  input  logic [1:0]                imode,
  input  logic                      istep,
  input  logic [COLOR_ID_WIDTH-1:0] ifg,
  output logic [SPIXEL_X_WIDTH-1:0] ox,
  output logic [SPIXEL_Y_WIDTH-1:0] oy,
  output logic [COLOR_ID_WIDTH-1:0] ocolor,
  output logic                      ovld,
  input  logic                      idone,
  output logic                      obusy,
  output logic                      ooverrun
);

  localparam logic [SPIXEL_X_WIDTH-1:0] X_LAST    = SPIXEL_X_WIDTH'(SPIXEL_X_MAX - 1);
  localparam logic [SPIXEL_Y_WIDTH-1:0] Y_LAST    = SPIXEL_Y_WIDTH'(SPIXEL_Y_MAX - 1);
  localparam logic [TICK_CNT_WIDTH-1:0] TICK_LAST = TICK_CNT_WIDTH'(TICK_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_ERASE,
    S_EWAIT,
    S_DRAW,
    S_DWAIT
  } state_t;

  state_t                      state, state_nxt;
  logic [TICK_CNT_WIDTH-1:0]   cnt;
  logic                        tick;
  logic                        trigger;
  logic [SPIXEL_X_WIDTH-1:0]   cur_x, nxt_x;
  logic [SPIXEL_Y_WIDTH-1:0]   cur_y, nxt_y;
  logic                        dir_x, dir_y;      // 1 = moving towards MAX-1
  logic                        nxt_dx, nxt_dy;
  logic                        first;
  logic [COLOR_ID_WIDTH-1:0]   fg;
  logic [COLOR_ID_WIDTH-1:0]   erase_color;

`ifdef SPIXEL_ANIM_TRAIL_EN
  localparam logic [COLOR_ID_WIDTH-1:0] MSB_MASK =
    COLOR_ID_WIDTH'(1) << (COLOR_ID_WIDTH - 1);
  assign erase_color = ifg ^ MSB_MASK;
`else
  assign erase_color = BG_COLOR;
`endif

  // Prescaler: free-runs while enabled, holds its count otherwise.
  assign tick = (cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ien) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    trigger = 1'b0;
    if (ien) begin
      case (imode)
        2'b00, 2'b01: trigger = tick;
        2'b10:        trigger = istep;
        default:      trigger = 1'b0;
      endcase
    end
  end

  // Next-cell computation, evaluated with the mode present during LATCH.
  always_comb begin
    nxt_x  = cur_x;
    nxt_y  = cur_y;
    nxt_dx = dir_x;
    nxt_dy = dir_y;
    case (imode)
      2'b00, 2'b10: begin
        if (cur_x == X_LAST) begin
          nxt_x = '0;
          nxt_y = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
        end else begin
          nxt_x = cur_x + 1'b1;
        end
      end
      2'b01: begin
        // A step that would leave the grid reverses that axis first.
        if (SPIXEL_X_MAX == 1) begin
          nxt_x = '0;
        end else if (dir_x) begin
          if (cur_x == X_LAST) begin
            nxt_x  = cur_x - 1'b1;
            nxt_dx = 1'b0;
          end else begin
            nxt_x = cur_x + 1'b1;
          end
        end else begin
          if (cur_x == '0) begin
            nxt_x  = cur_x + 1'b1;
            nxt_dx = 1'b1;
          end else begin
            nxt_x = cur_x - 1'b1;
          end
        end
        if (SPIXEL_Y_MAX == 1) begin
          nxt_y = '0;
        end else if (dir_y) begin
          if (cur_y == Y_LAST) begin
            nxt_y  = cur_y - 1'b1;
            nxt_dy = 1'b0;
          end else begin
            nxt_y = cur_y + 1'b1;
          end
        end else begin
          if (cur_y == '0) begin
            nxt_y  = cur_y + 1'b1;
            nxt_dy = 1'b1;
          end else begin
            nxt_y = cur_y - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ovld      = 1'b0;
    obusy     = 1'b1;
    case (state)
      S_IDLE: begin
        obusy = 1'b0;
        if (trigger) state_nxt = S_LATCH;
      end
      S_LATCH: state_nxt = first ? S_DRAW : S_ERASE;
      S_ERASE: begin
        ovld      = 1'b1;
        state_nxt = S_EWAIT;
      end
      S_EWAIT: if (idone) state_nxt = S_DRAW;
      S_DRAW: begin
        ovld      = 1'b1;
        state_nxt = S_DWAIT;
      end
      S_DWAIT: if (idone) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ox/oy/ocolor are loaded one cycle ahead of each request so they are
  // stable for the whole ERASE/EWAIT and DRAW/DWAIT windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x    <= '0;
      cur_y    <= '0;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      first    <= 1'b1;
      fg       <= '0;
      ox       <= '0;
      oy       <= '0;
      ocolor   <= '0;
      ooverrun <= 1'b0;
    end else begin
      if (trigger && obusy) ooverrun <= 1'b1;
      case (state)
        S_LATCH: begin
          fg <= ifg;
          ox <= cur_x;
          oy <= cur_y;
          if (first) begin
            // Very first move draws the reset cell without erasing.
            ocolor <= ifg;
          end else begin
            ocolor <= erase_color;
            cur_x  <= nxt_x;
            cur_y  <= nxt_y;
            dir_x  <= nxt_dx;
            dir_y  <= nxt_dy;
          end
        end
        S_EWAIT: begin
          if (idone) begin
            ox     <= cur_x;
            oy     <= cur_y;
            ocolor <= fg;
          end
        end
        S_DWAIT: begin
          if (idone) first <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spixel_animator.sv
module tb_spixel_animator;

  logic       clk = 1'b0;
  logic       rst;
  logic       ien;
  logic [1:0] imode;
  logic       istep;
  logic [7:0] ifg;
  logic [4:0] ox;
  logic [4:0] oy;
  logic [7:0] ocolor;
  logic       ovld;
  logic       idone = 1'b0;
  logic       obusy;
  logic       ooverrun;

  always #5 clk = ~clk;

  spixel_animator #(
    .SPIXEL_X_MAX(4),
    .SPIXEL_Y_MAX(3),
    .TICK_PERIOD (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ien     (ien),
    .imode   (imode),
    .istep   (istep),
    .ifg     (ifg),
    .ox      (ox),
    .oy      (oy),
    .ocolor  (ocolor),
    .ovld    (ovld),
    .idone   (idone),
    .obusy   (obusy),
    .ooverrun(ooverrun)
  );

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [7:0] c;
  } req_t;

  req_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   pops       = 0;

  // draw_superpixel stand-in: idone pulses in the third cycle after ovld.
  int dcnt = 0;
  always @(posedge clk) begin
    idone <= 1'b0;
    if (rst) begin
      dcnt <= 0;
    end else if (ovld) begin
      dcnt <= 2;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) idone <= 1'b1;
    end
  end

  // Monitor: every request is popped against the scoreboard.
  bit   pending = 0;
  req_t e;
  always @(negedge clk) begin
    if (rst) begin
      pending = 0;
    end else begin
      if (ovld) begin
        compared++;
        if (pending) begin
          mismatched++;
          $display("FAIL ovld_order: got ovld=1 with request pending, required idone first");
        end
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_ovld: got (%0d,%0d,%02h), required no request", ox, oy, ocolor);
        end else begin
          e = q.pop_front();
          pops++;
          if ({ox, oy, ocolor} !== e) begin
            mismatched++;
            $display("FAIL ovld_data: got (%0d,%0d,%02h), required (%0d,%0d,%02h)",
                     ox, oy, ocolor, e.x, e.y, e.c);
          end
        end
        pending = 1;
      end
      if (idone) pending = 0;
    end
  end

  task automatic push(input int x, input int y, input logic [7:0] c);
    req_t r;
    r.x = 5'(x);
    r.y = 5'(y);
    r.c = c;
    q.push_back(r);
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int n = 0;
    while (pops < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, pops, target);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (obusy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(obusy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  // Raster cells visited by ticks 1..13 and bounce cells for 11 ticks from (0,0).
  int rx[13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
  int ry[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
  int bx[12] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1};
  int by[12] = '{0, 1, 2, 1, 0, 1, 2, 1, 0, 1, 2, 1};

  initial begin
    int hold_ovld;
    int lat;
    rst = 1'b1; ien = 1'b0; imode = 2'b00; istep = 1'b0; ifg = 8'h0f;
    repeat (3) @(negedge clk);
    check("rst_ox", int'(ox), 0);
    check("rst_oy", int'(oy), 0);
    check("rst_ocolor", int'(ocolor), 0);
    check("rst_ovld", int'(ovld), 0);
    check("rst_obusy", int'(obusy), 0);
    check("rst_ooverrun", int'(ooverrun), 0);

    // Raster: first tick draws (0,0) only, then erase/draw through the wrap.
    push(0, 0, 8'h0f);
    for (int k = 1; k < 13; k++) begin
      push(rx[k-1], ry[k-1], 8'hff);
      push(rx[k], ry[k], 8'h0f);
    end
    rst = 1'b0; ien = 1'b1;
    wait_pops(25, 300, "raster_moves");
    ien = 1'b0;
    check("raster_no_overrun", int'(ooverrun), 0);
    wait_idle("raster_idle");

    // Bounce from (0,0) dir (+,+).
    imode = 2'b01; ifg = 8'h3c;
    for (int k = 1; k < 12; k++) begin
      push(bx[k-1], by[k-1], 8'hff);
      push(bx[k], by[k], 8'h3c);
    end
    ien = 1'b1;
    wait_pops(47, 300, "bounce_moves");
    ien = 1'b0;
    check("bounce_no_overrun", int'(ooverrun), 0);
    wait_idle("bounce_idle");

    // Step mode: a second pulse while busy is dropped and flags overrun.
    imode = 2'b10; ifg = 8'h5a; ien = 1'b1;
    push(1, 1, 8'hff); push(2, 1, 8'h5a);
    @(negedge clk); istep = 1'b1;
    @(negedge clk); istep = 1'b0;
    check("step_busy", int'(obusy), 1);
    @(negedge clk);
    check("overrun_before", int'(ooverrun), 0);
    istep = 1'b1;
    @(negedge clk); istep = 1'b0;
    check("overrun_set", int'(ooverrun), 1);
    wait_pops(49, 40, "step_move1");
    wait_idle("step_idle1");
    repeat (20) @(negedge clk);
    push(2, 1, 8'hff); push(3, 1, 8'h5a);
    istep = 1'b1;
    @(negedge clk); istep = 1'b0;
    wait_pops(51, 40, "step_move2");
    wait_idle("step_idle2");

    // Reset while waiting on the erase.
    push(3, 1, 8'hff);
    @(negedge clk); istep = 1'b1;
    @(negedge clk); istep = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_ovld", int'(ovld), 0);
    check("midrst_obusy", int'(obusy), 0);
    check("midrst_ooverrun", int'(ooverrun), 0);
    check("midrst_ox", int'(ox), 0);
    check("midrst_erase_seen", pops, 52);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // After reset the first move draws (0,0) without erase; a step on the
    // idone cycle is an overrun, a step one cycle later is accepted.
    push(0, 0, 8'h5a); push(0, 0, 8'hff); push(1, 0, 8'h5a);
    istep = 1'b1;
    @(negedge clk); istep = 1'b0;
    repeat (4) @(negedge clk);
    check("fall_busy", int'(obusy), 1);
    check("fall_overrun_before", int'(ooverrun), 0);
    istep = 1'b1;
    @(negedge clk);
    check("fall_obusy_low", int'(obusy), 0);
    check("fall_overrun_set", int'(ooverrun), 1);
    @(negedge clk); istep = 1'b0;
    check("fall_accepted", int'(obusy), 1);
    wait_pops(55, 40, "fall_moves");
    wait_idle("fall_idle");

    // Prescaler hold: 4 enabled cycles, 25 disabled, then tick after 5 more.
    rst = 1'b1; ien = 1'b0; imode = 2'b00; ifg = 8'h81;
    repeat (2) @(negedge clk);
    rst = 1'b0; ien = 1'b1;
    repeat (4) @(negedge clk);
    ien = 1'b0;
    hold_ovld = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ovld) hold_ovld++;
    end
    check("hold_no_ovld", hold_ovld, 0);
    push(0, 0, 8'h81);
    ien = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ovld) begin
        lat = i;
        break;
      end
    end
    check("hold_latency", lat, 7);
    imode = 2'b11;
    hold_ovld = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ovld) hold_ovld++;
    end
    check("mode11_no_ovld", hold_ovld, 0);
    check("mode11_idle", int'(obusy), 0);
    check("scoreboard_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
